// File: rtl/pitch_shift_cv_if.sv
// Sample-pipeline interface for pitch_shift_cv.
// master: drives the strobe and the four input samples, observes outputs.
// slave : the core; receives inputs, drives outputs and status.
//   sample_strobe        one-cycle pulse, sample_in* valid that cycle
//   sample_in0..3        audio in, pitch CV, two unused lanes
//   sample_out0..3       dry, shifted, 50/50 mix, grain phase sawtooth
//   out_valid            one-cycle pulse when sample_out* update
//   busy                 high while clearing or processing a sample
//   overrun              sticky, a strobe arrived while busy
interface pitch_shift_cv_if #(parameter int W = 16);
  logic         sample_strobe;
  logic [W-1:0] sample_in0;
  logic [W-1:0] sample_in1;
  logic [W-1:0] sample_in2;
  logic [W-1:0] sample_in3;
  logic [W-1:0] sample_out0;
  logic [W-1:0] sample_out1;
  logic [W-1:0] sample_out2;
  logic [W-1:0] sample_out3;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  modport master (
    output sample_strobe, sample_in0, sample_in1, sample_in2, sample_in3,
    input  sample_out0, sample_out1, sample_out2, sample_out3,
    input  out_valid, busy, overrun
  );

  modport slave (
    input  sample_strobe, sample_in0, sample_in1, sample_in2, sample_in3,
    output sample_out0, sample_out1, sample_out2, sample_out3,
    output out_valid, busy, overrun
  );
endinterface

// File: rtl/pitch_shift_cv.sv
// CV-controlled granular pitch shifter.
// Audio on sample_in0 is written into a 2*WINDOW circular buffer. Two taps
// spaced WINDOW apart are read at a speed set by the CV on sample_in1,
// linearly interpolated and crossfaded so the delay wrap happens on the tap
// whose gain is zero.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  pitch_shift_cv_if.slave (strobe, samples in/out, status)
//
// state  | meaning
// CLEAR  | zeroing the buffer, one address per clock
// IDLE   | waiting for a sample strobe
// WR     | write captured input at wp
// RDA0   | issue read, tap A at delay D
// RDA1   | issue read, tap A at delay D+1; latch x[D]
// RDB0   | issue read, tap B at delay D+WINDOW; form tap A
// RDB1   | issue read, tap B at delay D+WINDOW+1; latch x[D+WINDOW]
// MIX    | form tap B, crossfade and saturate
// OUT    | register outputs, advance wp and the delay accumulator
module pitch_shift_cv #(
  parameter int W         = 16,
  parameter int WINDOW    = 512,
  parameter int XFADE     = 64,
  parameter int FRAC_BITS = 4,
  parameter int INTERP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  pitch_shift_cv_if.slave  bus
);
  localparam int DEPTH = 2 * WINDOW;
  localparam int AW    = $clog2(DEPTH);
  localparam int WB    = $clog2(WINDOW);
  localparam int XB    = $clog2(XFADE);
  localparam int DW    = WB + FRAC_BITS;
  localparam int SW    = FRAC_BITS + 2;
  localparam int IW    = W + FRAC_BITS + 2;
  localparam int GW    = XB + 1;
  localparam int MW    = W + GW + 1;

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_WR, S_RDA0, S_RDA1, S_RDB0, S_RDB1, S_MIX, S_OUT
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          rdata;
  logic                  we;
  logic [AW-1:0]         waddr, raddr;
  logic [W-1:0]          wdata;

  logic [AW-1:0]         clr_addr;
  logic [AW-1:0]         wp;
  logic [DW-1:0]         d;
  logic signed [SW-1:0]  step;
  logic signed [W-1:0]   in0_q;
  logic signed [W-1:0]   x0;
  logic signed [W-1:0]   tap_a;
  logic signed [W-1:0]   mix_q;

  logic [WB-1:0]         dint;
  logic [FRAC_BITS-1:0]  frac;
  logic [AW-1:0]         dly, dly1;
  logic signed [IW-1:0]  diff, prod, interp;
  logic signed [W-1:0]   tap_now;
  logic [GW-1:0]         ga, gb;
  logic signed [MW-1:0]  sum;
  logic                  unused_ok;

  function automatic logic [W-1:0] sat_w(input logic signed [MW-1:0] v);
    logic signed [MW-1:0] hi, lo;
    hi = MW'({1'b0, {(W-1){1'b1}}});
    lo = ~hi;
    if (v > hi)      return hi[W-1:0];
    else if (v < lo) return lo[W-1:0];
    else             return v[W-1:0];
  endfunction

  assign dint = d[DW-1:FRAC_BITS];
  assign frac = d[FRAC_BITS-1:0];
  assign bus.busy = (state != S_IDLE);
  assign unused_ok = ^{bus.sample_in2, bus.sample_in3,
                       bus.sample_in1[W-SW-1:0], interp[IW-1:W]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: if (&clr_addr) state_nx = S_IDLE;
      S_IDLE:  if (bus.sample_strobe) state_nx = S_WR;
      S_WR:    state_nx = S_RDA0;
      S_RDA0:  state_nx = S_RDA1;
      S_RDA1:  state_nx = S_RDB0;
      S_RDB0:  state_nx = S_RDB1;
      S_RDB1:  state_nx = S_MIX;
      S_MIX:   state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep and the sample write.
  always_comb begin
    we    = 1'b0;
    waddr = wp;
    wdata = in0_q;
    if (state == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
    end else if (state == S_WR) begin
      we = 1'b1;
    end
  end

  // Read address; the +1 neighbour is clamped at the oldest entry.
  always_comb begin
    dly = AW'(dint);
    if (state == S_RDB0 || state == S_RDB1) dly = dly + AW'(WINDOW);
    dly1  = (&dly) ? dly : dly + AW'(1);
    raddr = wp - ((state == S_RDA1 || state == S_RDB1) ? dly1 : dly);
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  // x0 holds x[k]; rdata carries x[k+1] in RDB0 (tap A) and MIX (tap B).
  always_comb begin
    diff    = IW'($signed(rdata)) - IW'(x0);
    prod    = diff * IW'($signed({1'b0, frac}));
    interp  = IW'(x0) + (prod >>> FRAC_BITS);
    tap_now = (INTERP != 0) ? interp[W-1:0] : x0;
    ga      = (dint < WB'(XFADE)) ? dint[GW-1:0] : GW'(XFADE);
    gb      = GW'(XFADE) - ga;
    sum     = MW'(tap_a) * MW'($signed({1'b0, ga}))
            + MW'(tap_now) * MW'($signed({1'b0, gb}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr        <= '0;
      wp              <= '0;
      d               <= '0;
      step            <= '0;
      in0_q           <= '0;
      x0              <= '0;
      tap_a           <= '0;
      mix_q           <= '0;
      bus.sample_out0 <= '0;
      bus.sample_out1 <= '0;
      bus.sample_out2 <= '0;
      bus.sample_out3 <= '0;
      bus.out_valid   <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.sample_strobe && state != S_IDLE) bus.overrun <= 1'b1;
      case (state)
        S_CLEAR: clr_addr <= clr_addr + AW'(1);
        S_IDLE: begin
          if (bus.sample_strobe) begin
            in0_q <= bus.sample_in0;
            step  <= bus.sample_in1[W-1 -: SW];
          end
        end
        S_RDA1: x0 <= rdata;
        S_RDB0: tap_a <= tap_now;
        S_RDB1: x0 <= rdata;
        S_MIX:  mix_q <= sat_w(sum >>> XB);
        S_OUT: begin
          bus.sample_out0 <= in0_q;
          bus.sample_out1 <= mix_q;
          bus.sample_out2 <= sat_w(MW'(in0_q >>> 1) + MW'(mix_q >>> 1));
          bus.sample_out3 <= {dint, {(W-WB){1'b0}}};
          bus.out_valid   <= 1'b1;
          d               <= d - DW'(step);
          wp              <= wp + AW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
